max_pooling_layer: RTL and testbench
====================================

Name: max_pooling_layer

Overview:
- Downstream consumer of convolution_layer: accepts one convolved output row per enabled cycle on matrix_input_stream.
- Performs 2x2, stride-2 max pooling on unsigned elements.
- Emits one pooled row per input row pair, with a one-cycle valid pulse.
- Tracks frame height; odd trailing rows/columns are dropped.

Parameters:
- data_size, 4, bits per element (unsigned).
- max_input_matrix_width, 7, elements per input row (convolution output width, 9-3+1).
- max_input_matrix_height, 7, rows per frame.
- matrix_output_width (localparam), max_input_matrix_width/2 (floor), elements per pooled row.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- enable  input  1  input row valid; row sampled on rising edge when high.
- matrix_input_stream  input  data_size*max_input_matrix_width  input row; column c at bits [data_size*(max_input_matrix_width-c)-1 -: data_size] (column 0 at MSB).
- matrix_output_stream  output  data_size*matrix_output_width  pooled row; same column packing.
- output_valid  output  1  one-cycle pulse, new pooled row present.
- frame_done  output  1  one-cycle pulse, last row of frame accepted.
- is_buffer_full  output  1  high while one row is held awaiting its pair (state WAIT_SECOND).

Behaviour:
- Reset: when reset_n=0 at a clk edge, the following are cleared:
  - state=WAIT_FIRST, row_count=0, row buffer=0;
  - matrix_output_stream=0, output_valid=0, frame_done=0, is_buffer_full=0.
  - Reset has priority over enable.
- Reset mid-pair discards the buffered row. The next accepted row is treated as row 0 of a new frame.
- enable=0: state, counters, buffer and matrix_output_stream hold. output_valid and frame_done go 0.
- row_count: 0..max_input_matrix_height-1.
  - Increments on every accepted row.
  - Wraps to 0 after the row where row_count == max_input_matrix_height-1; frame_done=1 the following cycle.
- State WAIT_FIRST, enable=1:
  - Normal case: store the row in the buffer; go to WAIT_SECOND.
  - Exception: if the row is the last of the frame (odd height), discard it and stay in WAIT_FIRST. No output_valid.
- State WAIT_SECOND, enable=1:
  - For each k in 0..matrix_output_width-1: out[k] = max(buf[2k], buf[2k+1], in[2k], in[2k+1]), unsigned compare.
  - Register the result into matrix_output_stream; output_valid=1 next cycle for exactly one cycle.
  - Return to WAIT_FIRST.
- Latency: pooled row visible on the cycle after the edge accepting the second row of the pair.
- Odd width: column max_input_matrix_width-1 is ignored when width is odd.
- Ties: equal values give that value. The comparator tree is purely combinational, with registered output only.
- matrix_output_stream holds its last value until the next pooled row or reset.
- Simultaneous events: frame_done and output_valid may pulse in the same cycle (even height, last pair).
- Frame boundaries: no pair crosses a frame boundary; row_count wrap forces WAIT_FIRST.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles with enable=1 and random input -> matrix_output_stream=0, output_valid=0, frame_done=0, is_buffer_full=0.
- Basic pair:
  - Stimulus: row0=1 2 3 4 5 6 7, then row1=8 0 0 9 A 0 F, enable=1 on consecutive cycles.
  - Response: is_buffer_full=1 after row0.
  - One cycle after row1: matrix_output_stream=0x89A, output_valid=1 for one cycle. Column 6 (value 7/F) is ignored.
- Stall:
  - Stimulus: same rows with enable=0 for 3 cycles between them.
  - Response: is_buffer_full stays 1 during the gap; output 0x89A. Exactly one output_valid pulse, one cycle after row1.
- Full frame:
  - Stimulus: 7 rows, each row r all elements=r.
  - Response: output_valid pulses with 0x111, 0x333, 0x555.
  - Row 6 is discarded; frame_done pulses one cycle after row 6; no fourth output_valid.
  - The next row starts a new frame (row_count=0).
- Reset mid-pair:
  - Stimulus: row0=F F F F F F F; reset_n=0 one cycle; then row=1 1 1 1 1 1 1 and row=2 2 2 2 2 2 2.
  - Response: output=0x222, not 0xFFF.
- Unsigned compare:
  - Stimulus: rows 7 F 0 0 0 0 0 and 8 1 0 0 0 0 0.
  - Response: output 0xF00.

Source files
------------

// File: rtl/max_pooling_layer_if.sv
// Row stream bundle between an upstream convolution stage and the max pooling layer.
// The upstream stage (master) presents one row per enabled cycle; the pooling
// layer (slave) returns pooled rows together with frame and buffer status.
interface max_pooling_layer_if #(
    parameter int data_size              = 4,
    parameter int max_input_matrix_width = 7
);
    localparam int matrix_output_width = max_input_matrix_width / 2;

    logic                                          enable;
    logic [data_size*max_input_matrix_width-1:0]   matrix_input_stream;
    logic [data_size*matrix_output_width-1:0]      matrix_output_stream;
    logic                                          output_valid;
    logic                                          frame_done;
    logic                                          is_buffer_full;

    modport master (
        output enable,
        output matrix_input_stream,
        input  matrix_output_stream,
        input  output_valid,
        input  frame_done,
        input  is_buffer_full
    );

    modport slave (
        input  enable,
        input  matrix_input_stream,
        output matrix_output_stream,
        output output_valid,
        output frame_done,
        output is_buffer_full
    );
endinterface

// File: rtl/max_pooling_layer.sv
// 2x2 stride-2 max pooling over a stream of unsigned rows.
// The first row of each pair is held in a buffer; when its partner arrives the
// four-way maximum of every 2x2 window is registered as one pooled row.
// A trailing unpaired row (odd frame height) and an unpaired last column (odd
// width) are dropped.
module max_pooling_layer #(
    parameter int data_size               = 4,
    parameter int max_input_matrix_width  = 7,
    parameter int max_input_matrix_height = 7
) (
    input  logic                   clk,
    input  logic                   reset_n,
    max_pooling_layer_if.slave     bus
);
    localparam int matrix_output_width = max_input_matrix_width / 2;
    localparam int IN_BITS  = data_size * max_input_matrix_width;
    localparam int OUT_BITS = data_size * matrix_output_width;
    localparam int ROW_W    = (max_input_matrix_height > 1) ? $clog2(max_input_matrix_height) : 1;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(max_input_matrix_height - 1);

    localparam logic [0:0] WAIT_FIRST  = 1'b0;
    localparam logic [0:0] WAIT_SECOND = 1'b1;

    logic [0:0]          state_q,        state_d;
    logic [ROW_W-1:0]    rowCount_q,     rowCount_d;
    logic [IN_BITS-1:0]  buffer_q,       buffer_d;
    logic [OUT_BITS-1:0] outStream_q,    outStream_d;
    logic                outputValid_q,  outputValid_d;
    logic                frameDone_q,    frameDone_d;
    logic [OUT_BITS-1:0] pooledRow;
    logic                lastRow;

    function automatic logic [data_size-1:0] max2(input logic [data_size-1:0] a,
                                                   input logic [data_size-1:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic [data_size-1:0] column(input logic [IN_BITS-1:0] row,
                                                     input int c);
        return row[data_size*(max_input_matrix_width-c)-1 -: data_size];
    endfunction

    // Comparator tree: maximum of each 2x2 window of the buffered row and the incoming row.
    always_comb begin
        pooledRow = '0;
        for (int k = 0; k < matrix_output_width; k++) begin
            pooledRow[data_size*(matrix_output_width-k)-1 -: data_size] =
                max2(max2(column(buffer_q, 2*k), column(buffer_q, 2*k+1)),
                     max2(column(bus.matrix_input_stream, 2*k),
                          column(bus.matrix_input_stream, 2*k+1)));
        end
    end

    assign lastRow = (rowCount_q == LAST_ROW);

    // Next-state: pair rows, track frame position, drop an unpaired final row.
    always_comb begin
        state_d       = state_q;
        rowCount_d    = rowCount_q;
        buffer_d      = buffer_q;
        outStream_d   = outStream_q;
        outputValid_d = 1'b0;
        frameDone_d   = 1'b0;
        if (bus.enable) begin
            rowCount_d  = lastRow ? '0 : rowCount_q + 1'b1;
            frameDone_d = lastRow;
            if (state_q == WAIT_FIRST) begin
                if (!lastRow) begin
                    buffer_d = bus.matrix_input_stream;
                    state_d  = WAIT_SECOND;
                end
            end else begin
                outStream_d   = pooledRow;
                outputValid_d = 1'b1;
                state_d       = WAIT_FIRST;
            end
        end
    end

    // State registers with synchronous active-low reset taking priority over enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q       <= WAIT_FIRST;
            rowCount_q    <= '0;
            buffer_q      <= '0;
            outStream_q   <= '0;
            outputValid_q <= 1'b0;
            frameDone_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            rowCount_q    <= rowCount_d;
            buffer_q      <= buffer_d;
            outStream_q   <= outStream_d;
            outputValid_q <= outputValid_d;
            frameDone_q   <= frameDone_d;
        end
    end

    assign bus.matrix_output_stream = outStream_q;
    assign bus.output_valid         = outputValid_q;
    assign bus.frame_done           = frameDone_q;
    assign bus.is_buffer_full       = (state_q == WAIT_SECOND);
endmodule

// File: tb/tb_max_pooling_layer.sv
// Directed bench for max_pooling_layer: reset, basic pair, stall, full frame,
// reset mid-pair and unsigned comparison, with hand-computed expected rows.
module tb_max_pooling_layer;
    logic clk;
    logic reset_n;
    int   checkCount;
    int   passCount;
    int   failCount;

    max_pooling_layer_if #(.data_size(4), .max_input_matrix_width(7)) bus ();

    max_pooling_layer #(
        .data_size(4),
        .max_input_matrix_width(7),
        .max_input_matrix_height(7)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus.slave)
    );

    // Free-running 10-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [27:0] rep(input logic [3:0] v);
        return {7{v}};
    endfunction

    // Drive one cycle of inputs at the falling edge, then settle just after the rising edge.
    task automatic applyStimulus(input logic rstN, input logic en, input logic [27:0] row);
        @(negedge clk);
        reset_n                 = rstN;
        bus.enable              = en;
        bus.matrix_input_stream = row;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else begin
            failCount++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [11:0] expOut, input logic expValid,
                            input logic expDone, input logic expFull);
        checkOutput({tag, ".out"},   32'(bus.matrix_output_stream), 32'(expOut));
        checkOutput({tag, ".valid"}, 32'(bus.output_valid),         32'(expValid));
        checkOutput({tag, ".done"},  32'(bus.frame_done),           32'(expDone));
        checkOutput({tag, ".full"},  32'(bus.is_buffer_full),       32'(expFull));
    endtask

    // Linear sequence of directed steps.
    initial begin
        checkCount = 0;
        passCount  = 0;
        failCount  = 0;
        reset_n                 = 1'b0;
        bus.enable              = 1'b1;
        bus.matrix_input_stream = 28'($urandom);

        applyStimulus(1'b0, 1'b1, 28'($urandom));
        applyStimulus(1'b0, 1'b1, 28'($urandom));
        checkAll("reset", 12'h000, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 28'h1234567);
        checkAll("pair.row0", 12'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 28'h8009A0F);
        checkAll("pair.row1", 12'h89A, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 28'h0);
        checkAll("pair.after", 12'h89A, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 28'h1234567);
        checkAll("stall.row0", 12'h89A, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 28'($urandom));
            checkAll("stall.gap", 12'h89A, 1'b0, 1'b0, 1'b1);
        end
        applyStimulus(1'b1, 1'b1, 28'h8009A0F);
        checkAll("stall.row1", 12'h89A, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 28'h0);
        checkAll("stall.after", 12'h89A, 1'b0, 1'b0, 1'b0);

        applyStimulus(1'b0, 1'b0, 28'h0);
        checkAll("frame.reset", 12'h000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, rep(4'h0));
        checkAll("frame.r0", 12'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, rep(4'h1));
        checkAll("frame.r1", 12'h111, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, rep(4'h2));
        checkAll("frame.r2", 12'h111, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, rep(4'h3));
        checkAll("frame.r3", 12'h333, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, rep(4'h4));
        checkAll("frame.r4", 12'h333, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, rep(4'h5));
        checkAll("frame.r5", 12'h555, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, rep(4'h6));
        checkAll("frame.r6", 12'h555, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 1'b1, rep(4'hA));
        checkAll("frame.next0", 12'h555, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, rep(4'hB));
        checkAll("frame.next1", 12'hBBB, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, rep(4'hF));
        checkAll("midreset.row0", 12'hBBB, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 28'h0);
        checkAll("midreset.reset", 12'h000, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, rep(4'h1));
        checkAll("midreset.row1", 12'h000, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, rep(4'h2));
        checkAll("midreset.row2", 12'h222, 1'b1, 1'b0, 1'b0);

        applyStimulus(1'b1, 1'b1, 28'h7F00000);
        checkAll("unsigned.row0", 12'h222, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, 28'h8100000);
        checkAll("unsigned.row1", 12'hF00, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 28'h0);
        checkAll("unsigned.after", 12'hF00, 1'b0, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end
endmodule
